axi_rd_scheduler: RTL

Registered read-channel scheduler between the i-cache and d-cache refill ports and the single outer AXI read master. It arbitrates AR requests with round-robin fairness and captures the winner into a holding register, so cache-side handshakes are decoupled from outer `arready`. It allows at most one outstanding burst per requester, demultiplexes R beats by `rid`, and optionally blocks d-cache reads that hit a line with a write still in flight. It sits between the caches and the outer AXI port, beside the existing write path.

---
 rtl/axi_pkg.sv | 14 +
 rtl/axi_raw_tracker.sv | 35 +++
 rtl/axi_rd_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-path constants and the read scheduler state type.
package axi_pkg;

  localparam logic [3:0] AXI_ID_ICACHE  = 4'd0;
  localparam logic [3:0] AXI_ID_DCACHE  = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;

endpackage

// File: rtl/axi_raw_tracker.sv
// One-entry tracker of the cache line of the write currently in flight;
// flags d-cache reads that would overtake that write.
module axi_raw_tracker #(
  parameter int unsigned LINE_OFF_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aw_fire,
  input  logic [31:0] aw_addr,
  input  logic        b_fire,
  input  logic [31:0] rd_addr,
  output logic        raw_block
);

  logic                    valid;
  logic [31-LINE_OFF_W:0]  line;
  logic                    unused_offset;

  // A new AW wins over a same-cycle B so the fresh write stays tracked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      line  <= '0;
    end else if (aw_fire) begin
      valid <= 1'b1;
      line  <= aw_addr[31:LINE_OFF_W];
    end else if (b_fire) begin
      valid <= 1'b0;
    end
  end

  assign raw_block     = valid & (line == rd_addr[31:LINE_OFF_W]);
  assign unused_offset = ^{aw_addr[LINE_OFF_W-1:0], rd_addr[LINE_OFF_W-1:0]};

endmodule

// File: rtl/axi_rd_scheduler.sv
// Round-robin AR scheduler for i-cache/d-cache refills with one burst per
// requester and rid-based R demux. Define AXI_RAW_CHECK_EN for RAW blocking.
module axi_rd_scheduler
  import axi_pkg::*;
#(
  parameter int unsigned LINE_OFF_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [3:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [3:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic        aw_fire,
  input  logic [31:0] aw_addr,
  input  logic        b_fire,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rid_err
);

  sched_state_t state, state_nxt;
  logic last_grant;
  logic i_busy, d_busy;
  logic raw_block;
  logic i_elig, d_elig, sel, grant, ar_fire;
  logic r_sel, sel_busy, beat_done;
  logic unused_misc;

`ifdef AXI_RAW_CHECK_EN
  axi_raw_tracker #(.LINE_OFF_W(LINE_OFF_W)) u_raw_tracker (
    .clk       (clk),
    .rst       (rst),
    .aw_fire   (aw_fire),
    .aw_addr   (aw_addr),
    .b_fire    (b_fire),
    .rd_addr   (d_araddr),
    .raw_block (raw_block)
  );
  assign unused_misc = ^{rid[3:1], AXI_BURST_INCR};
`else
  assign raw_block   = 1'b0;
  assign unused_misc = ^{rid[3:1], AXI_BURST_INCR, aw_fire, aw_addr, b_fire,
                         (LINE_OFF_W == 32'd0)};
`endif

  always_comb begin
    i_elig    = i_arvalid & ~i_busy;
    d_elig    = d_arvalid & ~d_busy & ~raw_block;
    sel       = (i_elig & d_elig) ? ~last_grant : d_elig;
    grant     = (state == IDLE) & (i_elig | d_elig);
    ar_fire   = (state == ISSUE) & arready;
    state_nxt = state;
    case (state)
      IDLE:    if (grant)   state_nxt = ISSUE;
      ISSUE:   if (arready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign i_arready = grant & ~sel;
  assign d_arready = grant & sel;
  assign arvalid   = (state == ISSUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant) last_grant <= sel;
    end
  end

  // Holding register: only written in IDLE, so payload is frozen through ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arid   <= '0;
      araddr <= '0;
      arlen  <= '0;
      arsize <= '0;
    end else if (grant) begin
      arid   <= sel ? AXI_ID_DCACHE : AXI_ID_ICACHE;
      araddr <= sel ? d_araddr : i_araddr;
      arlen  <= sel ? d_arlen : i_arlen;
      arsize <= sel ? d_arsize : AXI_SIZE_WORD;
    end
  end

  assign r_sel     = rid[0];
  assign sel_busy  = r_sel ? d_busy : i_busy;
  assign beat_done = rvalid & rready & rlast & sel_busy;

  // Beats for a requester with nothing outstanding are swallowed, never stalled.
  assign rready   = ~sel_busy | (r_sel ? d_rready : i_rready);
  assign i_rvalid = rvalid & ~r_sel & i_busy;
  assign d_rvalid = rvalid & r_sel & d_busy;
  assign i_rlast  = rlast & ~r_sel;
  assign d_rlast  = rlast & r_sel;
  assign i_rdata  = r_sel ? '0 : rdata;
  assign d_rdata  = r_sel ? rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_busy  <= 1'b0;
      d_busy  <= 1'b0;
      rid_err <= 1'b0;
    end else begin
      if (beat_done & ~r_sel) i_busy <= 1'b0;
      if (beat_done & r_sel)  d_busy <= 1'b0;
      if (ar_fire & ~arid[0]) i_busy <= 1'b1;
      if (ar_fire & arid[0])  d_busy <= 1'b1;
      if (rvalid & ~sel_busy) rid_err <= 1'b1;
    end
  end

endmodule
